gb_intctl: RTL and testbench



---
 rtl/gb_pkg.sv | 31 +++
 rtl/gb_intctl_if.sv | 30 +++
 rtl/gb_prio_enc.sv | 30 +++
 rtl/gb_intctl.sv | 140 ++++++++++++++
 tb/tb_gb_intctl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_pkg
//  Description : Shared constants and types for the Game Boy interrupt
//                controller: source bit indices, register addresses,
//                vector layout and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package gb_pkg;

    localparam int c_nsrc = 5;

    // Source bit indices; lower index means higher priority
    localparam int c_int_vblank = 0;
    localparam int c_int_stat   = 1;
    localparam int c_int_timer  = 2;
    localparam int c_int_serial = 3;
    localparam int c_int_joypad = 4;

    localparam logic [15:0] c_if_addr    = 16'hFF0F;
    localparam logic [15:0] c_ie_addr    = 16'hFFFF;
    localparam logic [15:0] c_vec_base   = 16'h0040;
    localparam logic [15:0] c_vec_stride = 16'h0008;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gb_intctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gb_intctl_if
//  Description : CPU-side bus and interrupt handshake of the interrupt
//                controller. master = CPU, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface gb_intctl_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        load;
    logic        store;
    logic [7:0]  rdata;
    logic        rsel;
    logic        intreq;
    logic [15:0] intaddress;
    logic        intack;
    logic        wake;

    modport master (
        output address, wdata, load, store, intack,
        input  rdata, rsel, intreq, intaddress, wake
    );

    modport slave (
        input  address, wdata, load, store, intack,
        output rdata, rsel, intreq, intaddress, wake
    );
endinterface
`default_nettype wire

// File: rtl/gb_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : gb_prio_enc
//  Description : Lowest-set-bit encoder. idx is the index of the lowest set
//                bit of req (0 when req is zero); any flags a non-zero req.
//  Revision    : 1.0  initial release
// ============================================================================
module gb_prio_enc #(
    parameter int W  = 5,
    parameter int IW = 3
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set bit is the last to write idx
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/gb_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : gb_intctl
//  Description : Game Boy interrupt controller. Edge-captures the peripheral
//                sources into IF, masks with IE, latches one vector for the
//                CPU and retires it on intack. IF/IE are memory mapped.
//                NSRC must not exceed 8 (IF/IE share an 8-bit data bus).
//  Revision    : 1.0  initial release
// ============================================================================
module gb_intctl
    import gb_pkg::*;
#(
    parameter int          NSRC       = c_nsrc,
    parameter logic [15:0] VEC_BASE   = c_vec_base,
    parameter logic [15:0] VEC_STRIDE = c_vec_stride,
    parameter logic [15:0] IF_ADDR    = c_if_addr,
    parameter logic [15:0] IE_ADDR    = c_ie_addr
) (
    input  logic            clock4,
    input  logic            resetn,
    input  logic [NSRC-1:0] src,
    gb_intctl_if.slave      bus
);

    localparam int c_iw = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_if;
    logic [7:0]      r_ie;
    state_t          r_state;
    logic [c_iw-1:0] r_vec_idx;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pending;
    logic [NSRC-1:0] w_if_next;
    logic [c_iw-1:0] w_enc_idx;
    logic            w_enc_any;
    logic            w_if_wr;
    logic            w_ie_wr;
    logic            w_ack;
    state_t          w_state_next;
    logic [c_iw-1:0] w_vec_next;
    logic [7:0]      w_rdata;

    assign w_rise    = src & ~r_src_q;
    assign w_pending = r_ie[NSRC-1:0] & r_if;
    assign w_if_wr   = bus.store && (bus.address == IF_ADDR);
    assign w_ie_wr   = bus.store && (bus.address == IE_ADDR);
    // An ack only retires a bit while a vector is actually latched
    assign w_ack     = bus.intack && (r_state == ST_ARMED);

    gb_prio_enc #(
        .W  (NSRC),
        .IW (c_iw)
    ) u_prio (
        .req (w_pending),
        .idx (w_enc_idx),
        .any (w_enc_any)
    );

    // Per-bit IF update: new edge beats ack-clear, which beats a CPU write
    always_comb begin
        w_if_next = r_if;
        for (int i = 0; i < NSRC; i++) begin
            if (w_rise[i]) begin
                w_if_next[i] = 1'b1;
            end else if (w_ack && (r_vec_idx == c_iw'(i))) begin
                w_if_next[i] = 1'b0;
            end else if (w_if_wr) begin
                w_if_next[i] = bus.wdata[i];
            end
        end
    end

    // Source history (reset high to suppress edges present at reset), IF, IE
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            r_src_q <= '1;
            r_if    <= '0;
            r_ie    <= 8'h00;
        end else begin
            r_src_q <= src;
            r_if    <= w_if_next;
            if (w_ie_wr) begin
                r_ie <= bus.wdata;
            end
        end
    end

    // Dispatch FSM next state; the vector is frozen while ARMED
    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_any) begin
                    w_state_next = ST_ARMED;
                    w_vec_next   = w_enc_idx;
                end
            end
            ST_ARMED: begin
                if (bus.intack || !w_pending[r_vec_idx]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Dispatch FSM state register
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_vec_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_vec_idx <= w_vec_next;
        end
    end

    // Register read mux; unmapped addresses float high
    always_comb begin
        w_rdata = 8'hFF;
        if (bus.address == IF_ADDR) begin
            w_rdata = {{(8 - NSRC){1'b1}}, r_if};
        end else if (bus.address == IE_ADDR) begin
            w_rdata = r_ie;
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.rsel       = bus.load && ((bus.address == IF_ADDR) || (bus.address == IE_ADDR));
    assign bus.intreq     = (r_state == ST_ARMED);
    assign bus.intaddress = (r_state == ST_ARMED)
                          ? (VEC_BASE + VEC_STRIDE * {{(16 - c_iw){1'b0}}, r_vec_idx})
                          : 16'h0000;
    assign bus.wake       = |w_pending;

endmodule
`default_nettype wire

// File: tb/tb_gb_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_intctl
//  Description : Directed self-checking bench for gb_intctl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gb_intctl;
    import gb_pkg::*;

    logic       clock4;
    logic       resetn;
    logic [4:0] src;
    int         n_total;
    int         n_bad;
    logic [7:0] rd_val;

    gb_intctl_if bus ();

    gb_intctl u_dut (
        .clock4 (clock4),
        .resetn (resetn),
        .src    (src),
        .bus    (bus.slave)
    );

    initial clock4 = 1'b0;
    always #5 clock4 = ~clock4;

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clock4);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.store   = 1'b1;
        tick();
        bus.store   = 1'b0;
        bus.address = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.address = a;
        bus.load    = 1'b1;
        #1;
        d = bus.rdata;
        bus.load    = 1'b0;
        bus.address = 16'h0000;
    endtask

    task automatic ack();
        bus.intack = 1'b1;
        tick();
        bus.intack = 1'b0;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        resetn      = 1'b0;
        src         = 5'h1F;
        bus.address = 16'h0000;
        bus.wdata   = 8'h00;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        bus.intack  = 1'b0;

        // Reset with all sources high; no spurious edge on release
        repeat (3) tick();
        chk("rst_intreq", {15'd0, bus.intreq}, 16'd0);
        chk("rst_intaddr", bus.intaddress, 16'h0000);
        resetn = 1'b1;
        repeat (3) tick();
        chk("hold_intreq", {15'd0, bus.intreq}, 16'd0);
        chk("hold_wake", {15'd0, bus.wake}, 16'd0);
        bus.address = c_if_addr;
        bus.load    = 1'b1;
        #1;
        chk("rd_if_rst", {8'h00, bus.rdata}, 16'h00E0);
        chk("rsel_if", {15'd0, bus.rsel}, 16'd1);
        bus.address = 16'h1234;
        #1;
        chk("rd_other", {8'h00, bus.rdata}, 16'h00FF);
        chk("rsel_other", {15'd0, bus.rsel}, 16'd0);
        bus.load = 1'b0;
        rd(c_ie_addr, rd_val);
        chk("rd_ie_rst", {8'h00, rd_val}, 16'h0000);

        // Timer pulse with IE=05
        wr(c_ie_addr, 8'h05);
        src = 5'h00;
        tick();
        src = 5'h04;
        tick();
        src = 5'h00;
        rd(c_if_addr, rd_val);
        chk("tmr_if", {8'h00, rd_val}, 16'h00E4);
        chk("tmr_intreq_c1", {15'd0, bus.intreq}, 16'd0);
        tick();
        chk("tmr_intreq_c2", {15'd0, bus.intreq}, 16'd1);
        chk("tmr_vec", bus.intaddress, 16'h0050);
        ack();
        rd(c_if_addr, rd_val);
        chk("tmr_if_ack", {8'h00, rd_val}, 16'h00E0);
        chk("tmr_intreq_ack", {15'd0, bus.intreq}, 16'd0);

        // Priority and vector hold while ARMED
        wr(c_ie_addr, 8'h1F);
        wr(c_if_addr, 8'h18);
        tick();
        chk("pri_vec_serial", bus.intaddress, 16'h0058);
        src = 5'h01;
        tick();
        src = 5'h00;
        tick();
        chk("pri_vec_hold", bus.intaddress, 16'h0058);
        ack();
        chk("pri_idle", {15'd0, bus.intreq}, 16'd0);
        tick();
        chk("pri_vec_vblank", bus.intaddress, 16'h0040);
        ack();
        tick();
        chk("pri_vec_joypad", bus.intaddress, 16'h0060);
        ack();
        rd(c_if_addr, rd_val);
        chk("pri_if_clear", {8'h00, rd_val}, 16'h00E0);

        // New edge in the ack cycle wins over the clear
        src = 5'h04;
        tick();
        src = 5'h00;
        tick();
        chk("edge_vec", bus.intaddress, 16'h0050);
        bus.intack = 1'b1;
        src        = 5'h04;
        tick();
        bus.intack = 1'b0;
        src        = 5'h00;
        chk("edge_idle", {15'd0, bus.intreq}, 16'd0);
        rd(c_if_addr, rd_val);
        chk("edge_if_kept", {8'h00, rd_val}, 16'h00E4);
        tick();
        chk("edge_rearm", bus.intaddress, 16'h0050);
        ack();

        // IF write cancels an armed dispatch; stray ack in IDLE is ignored
        src = 5'h02;
        tick();
        src = 5'h00;
        tick();
        chk("cancel_vec", bus.intaddress, 16'h0048);
        wr(c_if_addr, 8'h00);
        tick();
        chk("cancel_intreq", {15'd0, bus.intreq}, 16'd0);
        chk("cancel_intaddr", bus.intaddress, 16'h0000);
        src = 5'h08;
        tick();
        src = 5'h00;
        ack();
        rd(c_if_addr, rd_val);
        chk("idle_ack_if", {8'h00, rd_val}, 16'h00E8);
        tick();
        chk("idle_ack_rearm", bus.intaddress, 16'h0058);
        ack();

        // Masked source, then wake on IE write
        wr(c_ie_addr, 8'h00);
        src = 5'h10;
        tick();
        src = 5'h00;
        tick();
        rd(c_if_addr, rd_val);
        chk("mask_if", {8'h00, rd_val}, 16'h00F0);
        chk("mask_intreq", {15'd0, bus.intreq}, 16'd0);
        chk("mask_wake", {15'd0, bus.wake}, 16'd0);
        wr(c_ie_addr, 8'h10);
        chk("unmask_wake", {15'd0, bus.wake}, 16'd1);
        chk("unmask_intreq_c0", {15'd0, bus.intreq}, 16'd0);
        tick();
        chk("unmask_intreq_c1", {15'd0, bus.intreq}, 16'd1);
        chk("unmask_vec", bus.intaddress, 16'h0060);

        // Asynchronous reset drops the dispatch immediately
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_intreq", {15'd0, bus.intreq}, 16'd0);
        chk("arst_intaddr", bus.intaddress, 16'h0000);
        chk("arst_wake", {15'd0, bus.wake}, 16'd0);
        rd(c_ie_addr, rd_val);
        chk("arst_ie", {8'h00, rd_val}, 16'h0000);
        tick();
        resetn = 1'b1;
        repeat (2) tick();
        chk("arst_idle", {15'd0, bus.intreq}, 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
